// File: rtl/cproc_sequencer_pkg.sv
// Shared definitions for the processor instruction sequencer: opcodes,
// FSM state encoding and instruction-word field positions.
package cproc_sequencer_pkg;

  localparam logic [1:0] OP_MVI = 2'b00;
  localparam logic [1:0] OP_MV  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2,
    ST_WAIT  = 2'd3
  } state_e;

  // Field LSB positions counted above the DW-bit immediate: {F, Rx, Ry, imm}
  localparam int F_OFS  = 4;
  localparam int RX_OFS = 2;
  localparam int RY_OFS = 0;

endpackage

// File: rtl/cproc_sequencer_if.sv
// Sequencer-to-processor link: one-cycle instruction strobe out, completion
// flag and result bus back.
interface cproc_sequencer_if #(
  parameter int DW = 8
);
  // w is a single-cycle valid carrying F/Rx/Ry/Data; the initiator keeps the
  // fields stable until Done, and BusWires is meaningful only while Done=1.
  logic          w;
  logic [1:0]    F;
  logic [1:0]    Rx;
  logic [1:0]    Ry;
  logic [DW-1:0] Data;
  logic          Done;
  logic [DW-1:0] BusWires;

  modport master (output w, F, Rx, Ry, Data, input Done, BusWires);
  modport slave  (input w, F, Rx, Ry, Data, output Done, BusWires);
endinterface

// File: rtl/cproc_sequencer_seq_prog_ram.sv
// Single-port program store: synchronous write, registered synchronous read.
// The read register holds its value until the next read enable.
module seq_prog_ram #(
  parameter int AW = 4,
  parameter int WW = 14
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [WW-1:0] wdata,
  output logic [WW-1:0] rdata
);

  logic [WW-1:0] mem_q [0:(1<<AW)-1];
  logic [WW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
    if (re) rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/cproc_sequencer.sv
// Issues a host-loaded program to the 4-register multi-cycle processor one
// instruction at a time, waiting for Done and capturing each bus result.
module cproc_sequencer
  import cproc_sequencer_pkg::*;
#(
  parameter int AW      = 4,
  parameter int DW      = 8,
  parameter int TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              Resetn,
  input  logic              prog_we,
  input  logic [AW-1:0]     prog_addr,
  input  logic [DW+5:0]     prog_din,
  input  logic [AW-1:0]     last_addr,
  input  logic              start,
  cproc_sequencer_if.master proc,
  output logic              busy,
  output logic [AW-1:0]     pc,
  output logic [DW-1:0]     result,
  output logic              result_valid,
  output logic              prog_done,
  output logic              error,
  output state_e            dbg_state
);

  localparam int IW = DW + 6;
  localparam int TW = $clog2(TIMEOUT + 1);

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] lastr_q, lastr_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [DW-1:0] result_q, result_d;
  logic          result_valid_q, result_valid_d;
  logic          prog_done_q, prog_done_d;
  logic          error_q, error_d;

  logic          ram_we;
  logic          ram_re;
  logic [AW-1:0] ram_addr;
  logic [IW-1:0] instr;
  logic          active;
  logic [1:0]    op;

  // The RAM read register doubles as the instruction register; it is only
  // reloaded in FETCH so it stays stable through ISSUE and WAIT.
  seq_prog_ram #(.AW(AW), .WW(IW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (prog_din),
    .rdata (instr)
  );

  assign ram_we   = prog_we && (state_q == ST_IDLE);
  assign ram_addr = (state_q == ST_IDLE) ? prog_addr : pc_q;

  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      state_q        <= ST_IDLE;
      pc_q           <= '0;
      lastr_q        <= '0;
      tmo_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      prog_done_q    <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      lastr_q        <= lastr_d;
      tmo_q          <= tmo_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      prog_done_q    <= prog_done_d;
      error_q        <= error_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    lastr_d        = lastr_q;
    tmo_d          = tmo_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    prog_done_d    = 1'b0;
    error_d        = error_q;
    ram_re         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
          pc_d    = '0;
          lastr_d = last_addr;
          error_d = 1'b0;
        end
      end
      ST_FETCH: begin
        ram_re  = 1'b1;
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        tmo_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (proc.Done) begin
          result_d       = proc.BusWires;
          result_valid_d = 1'b1;
          if (pc_q == lastr_q) begin
            state_d     = ST_IDLE;
            prog_done_d = 1'b1;
          end else begin
            pc_d    = pc_q + AW'(1);
            state_d = ST_FETCH;
          end
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Instruction fields are gated by state so they read 0 outside an
  // instruction and drop straight away when reset forces IDLE.
  assign active     = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign op         = instr[DW+F_OFS +: 2];
  assign proc.w     = (state_q == ST_ISSUE);
  assign proc.F     = active ? op : 2'b00;
  assign proc.Rx    = active ? instr[DW+RX_OFS +: 2] : 2'b00;
  assign proc.Ry    = active ? instr[DW+RY_OFS +: 2] : 2'b00;
  assign proc.Data  = (active && op == OP_MVI) ? instr[DW-1:0] : '0;

  assign busy         = (state_q != ST_IDLE);
  assign pc           = pc_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign prog_done    = prog_done_q;
  assign error        = error_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_cproc_sequencer.sv
// Bench for cproc_sequencer: a behavioural 4-register processor answers the
// instruction strobes, and a result scoreboard checks every completion.
module tb_cproc_sequencer;
  import cproc_sequencer_pkg::*;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int TIMEOUT = 8;
  localparam int IW = DW + 6;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          Resetn = 1'b0;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [IW-1:0] prog_din = '0;
  logic [AW-1:0] last_addr = '0;
  logic          start = 1'b0;
  logic          busy;
  logic [AW-1:0] pc;
  logic [DW-1:0] result;
  logic          result_valid;
  logic          prog_done;
  logic          error;
  state_e        dbg_state;

  always #5 clk = ~clk;

  cproc_sequencer_if #(.DW(DW)) pif ();

  cproc_sequencer #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .Resetn       (Resetn),
    .prog_we      (prog_we),
    .prog_addr    (prog_addr),
    .prog_din     (prog_din),
    .last_addr    (last_addr),
    .start        (start),
    .proc         (pif),
    .busy         (busy),
    .pc           (pc),
    .result       (result),
    .result_valid (result_valid),
    .prog_done    (prog_done),
    .error        (error),
    .dbg_state    (dbg_state)
  );

  // ---------------- processor model ----------------
  // mode: 0 normal, 1 never completes, 2 Done lingers two cycles after completion
  int            mode = 0;
  int unsigned   mt = 0;
  logic [1:0]    m_op = 2'b00, m_rx = 2'b00, m_ry = 2'b00;
  logic [DW-1:0] m_r [4] = '{default: '0};
  logic [DW-1:0] bus_hold = '0;
  logic [DW-1:0] bus_val;
  int            sticky_left = 0;
  logic          m_done;

  function automatic int unsigned lat_of(input logic [1:0] f);
    return (f == OP_MVI || f == OP_MV) ? 2 : 4;
  endfunction

  always_comb begin
    m_done  = (mode != 1) && (mt != 0) && (mt == lat_of(m_op));
    bus_val = '0;
    case (m_op)
      OP_MVI:  bus_val = pif.Data;
      OP_MV:   bus_val = m_r[m_ry];
      OP_ADD:  bus_val = m_r[m_rx] + m_r[m_ry];
      default: bus_val = m_r[m_rx] - m_r[m_ry];
    endcase
  end

  assign pif.Done     = m_done || (sticky_left > 0);
  assign pif.BusWires = m_done ? bus_val : bus_hold;

  always @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      mt          <= 0;
      sticky_left <= 0;
    end else begin
      if (pif.w) begin
        mt   <= 1;
        m_op <= pif.F;
        m_rx <= pif.Rx;
        m_ry <= pif.Ry;
      end else if (m_done) begin
        mt <= 0;
      end else if (mt != 0 && mt < 100) begin
        mt <= mt + 1;
      end
      if (m_done) begin
        m_r[m_rx]   <= bus_val;
        bus_hold    <= bus_val;
        sticky_left <= (mode == 2) ? 2 : 0;
      end else if (sticky_left > 0) begin
        sticky_left <= sticky_left - 1;
      end
    end
  end

  // ---------------- scoreboard state ----------------
  logic [DW-1:0] exp_q[$];
  logic [IW-1:0] prog_mem [1<<AW] = '{default: '0};
  logic [DW-1:0] ref_r [4] = '{default: '0};
  logic [DW-1:0] issued_data = '0;
  int n_chk = 0;
  int n_bad = 0;
  int w_cnt, rv_cnt, pd_cnt;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [IW-1:0] ins(input logic [1:0] f, input logic [1:0] rx,
                                        input logic [1:0] ry, input logic [DW-1:0] imm);
    return {f, rx, ry, imm};
  endfunction

  // Reference execution of prog_mem[0..last]: pushes expected bus results
  // and returns the expected number of busy cycles.
  task automatic eval_prog(input int last, output int cyc);
    logic [IW-1:0] iw;
    logic [1:0]    f, rx, ry;
    logic [DW-1:0] v;
    cyc = 0;
    for (int i = 0; i <= last; i++) begin
      iw = prog_mem[i];
      f  = iw[IW-1 -: 2];
      rx = iw[DW+3 -: 2];
      ry = iw[DW+1 -: 2];
      case (f)
        OP_MVI:  v = iw[DW-1:0];
        OP_MV:   v = ref_r[ry];
        OP_ADD:  v = ref_r[rx] + ref_r[ry];
        default: v = ref_r[rx] - ref_r[ry];
      endcase
      ref_r[rx] = v;
      exp_q.push_back(v);
      cyc += (f == OP_MVI || f == OP_MV) ? 4 : 6;
    end
  endtask

  // Sampled on the falling edge, away from the active edge.
  task automatic monitor();
    logic [IW-1:0] iw;
    logic [DW-1:0] ed;
    if (pif.w) begin
      w_cnt++;
      iw = prog_mem[pc];
      ed = (iw[IW-1 -: 2] == OP_MVI) ? iw[DW-1:0] : '0;
      chk_eq("issue", {pif.F, pif.Rx, pif.Ry, pif.Data}, {iw[IW-1:DW], ed});
      if (pif.F == OP_SUB) chk_eq("sub_data", pif.Data, 0);
      issued_data = pif.Data;
    end
    if (dbg_state == ST_WAIT) chk_eq("wait_data", {pif.w, pif.Data}, {1'b0, issued_data});
    if (result_valid) begin
      rv_cnt++;
      if (exp_q.size() == 0) chk_eq("extra_result", result_valid, 0);
      else chk_eq("result", result, exp_q.pop_front());
    end
    if (prog_done) pd_cnt++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [IW-1:0] wd);
    prog_we     = 1'b1;
    prog_addr   = AW'(a);
    prog_din    = wd;
    prog_mem[a] = wd;
    step();
    prog_we = 1'b0;
  endtask

  task automatic load_a();
    load(0, ins(OP_MVI, 2'd0, 2'd0, 8'h05));
    load(1, ins(OP_MVI, 2'd1, 2'd0, 8'h03));
    load(2, ins(OP_ADD, 2'd0, 2'd1, 8'h00));
  endtask

  task automatic run_prog(input string tag, input int last, input int md, input bit poke,
                          input bit wr0, input logic [IW-1:0] w0);
    int exp_cyc;
    int exp_w;
    int cyc;
    mode   = md;
    w_cnt  = 0;
    rv_cnt = 0;
    pd_cnt = 0;
    if (wr0) begin
      prog_we     = 1'b1;
      prog_addr   = '0;
      prog_din    = w0;
      prog_mem[0] = w0;
    end
    if (md == 1) begin
      exp_cyc = 2 + TIMEOUT;
      exp_w   = 1;
    end else begin
      eval_prog(last, exp_cyc);
      exp_w = last + 1;
    end
    last_addr = AW'(last);
    start     = 1'b1;
    step();
    start   = 1'b0;
    prog_we = 1'b0;
    chk_eq({tag, "_err_clr"}, error, 0);
    cyc = 0;
    while (busy && cyc < 400) begin
      if (poke && cyc == 5) begin
        start     = 1'b1;
        prog_we   = 1'b1;
        prog_addr = AW'(1);
        prog_din  = '1;
      end
      step();
      cyc++;
      start   = 1'b0;
      prog_we = 1'b0;
    end
    step();
    step();
    chk_eq({tag, "_cycles"}, cyc, exp_cyc);
    chk_eq({tag, "_w_pulses"}, w_cnt, exp_w);
    chk_eq({tag, "_rv_pulses"}, rv_cnt, (md == 1) ? 0 : last + 1);
    chk_eq({tag, "_done_pulses"}, pd_cnt, (md == 1) ? 0 : 1);
    chk_eq({tag, "_error"}, error, (md == 1) ? 1 : 0);
    chk_eq({tag, "_pc_end"}, pc, (md == 1) ? 0 : last);
    chk_eq({tag, "_pending"}, exp_q.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc;
    int n;
    Resetn = 1'b0;
    repeat (3) step();
    chk_eq("rst_outs", {pif.w, pif.F, pif.Rx, pif.Ry, pif.Data, busy, pc, result,
                        result_valid, prog_done, error}, 0);
    chk_eq("rst_state", dbg_state, ST_IDLE);
    Resetn = 1'b1;
    step();

    load_a();
    run_prog("progA", 2, 0, 1'b0, 1'b0, '0);
    chk_eq("progA_final", result, 8'h08);

    load(0, ins(OP_MVI, 2'd2, 2'd0, 8'h10));
    load(1, ins(OP_MVI, 2'd3, 2'd0, 8'h11));
    load(2, ins(OP_SUB, 2'd2, 2'd3, 8'h5A));
    run_prog("progB", 2, 0, 1'b0, 1'b0, '0);
    chk_eq("progB_final", result, 8'hFF);

    load(0, ins(OP_MVI, 2'd0, 2'd0, 8'h42));
    run_prog("timeout", 0, 1, 1'b0, 1'b0, '0);
    chk_eq("timeout_busy", busy, 0);
    run_prog("after_tmo", 0, 0, 1'b0, 1'b0, '0);
    chk_eq("after_tmo_final", result, 8'h42);

    load_a();
    run_prog("poke", 2, 0, 1'b1, 1'b0, '0);
    run_prog("readback", 2, 0, 1'b0, 1'b0, '0);

    // Reset during the first WAIT cycle of the add
    mode = 0;
    eval_prog(2, cyc);
    last_addr = AW'(2);
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 0;
    while (!(dbg_state == ST_WAIT && pif.F == OP_ADD) && cyc < 100) begin
      step();
      cyc++;
    end
    chk_eq("rstmid_reach", {dbg_state, pif.F}, {ST_WAIT, OP_ADD});
    #2;
    Resetn = 1'b0;
    #1;
    chk_eq("rstmid_outs", {pif.w, busy, pc, result}, 0);
    chk_eq("rstmid_state", dbg_state, ST_IDLE);
    exp_q.delete();
    step();
    step();
    chk_eq("rstmid_pulses", {result_valid, prog_done, pif.w}, 0);
    Resetn = 1'b1;
    step();
    run_prog("after_rst", 2, 0, 1'b0, 1'b0, '0);

    run_prog("sticky", 2, 2, 1'b0, 1'b0, '0);
    mode = 0;
    repeat (3) step();

    run_prog("wr_start", 0, 0, 1'b0, 1'b1, ins(OP_MVI, 2'd1, 2'd0, 8'h77));
    chk_eq("wr_start_final", result, 8'h77);

    for (int i = 0; i < (1 << AW); i++)
      load(i, ins(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 8'($urandom_range(0, 255))));
    run_prog("wrap", (1 << AW) - 1, 0, 1'b0, 1'b0, '0);

    n = $urandom_range(3, 8);
    for (int i = 0; i < n; i++)
      load(i, ins(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 8'($urandom_range(0, 255))));
    run_prog("rand", n - 1, 0, 1'b0, 1'b0, '0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d bad=%0d", n_chk, n_bad);
    $fatal(1);
  end

endmodule
